// File: rtl/cpu_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ram_loader
// Description : Copies a length-prefixed program from a synchronous
//               instruction ROM into CPU RAM starting at BASE_ADDR. ROM word 0
//               holds the instruction count; words 1..n are the program.
//               The count is clamped so the RAM address never wraps, and the
//               clamp is reported on 'overflow'. 'hold' freezes the loader
//               in its ROM-fetch states for single stepping.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CPU_LOADER_VERIFY_EN
//   defined   : every word is read back (VRD/VCMP) after its write and
//               compared; a mismatch sets the sticky 'verify_err'.
//               4 cycles per word.
//   undefined : no read-back; ram_re and verify_err are constant 0.
//               2 cycles per word.
// ----------------------------------------------------------------------------
// Ports
//   step_clk    in   1       clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   start       in   1       one-cycle load request (accepted in IDLE/DONE)
//   hold        in   1       single-step freeze (LEN and FETCH only)
//   rom_addr    out  ADDR_W  ROM address
//   rom_re      out  1       ROM read strobe (data valid next cycle)
//   rom_data    in   DATA_W  ROM read data
//   ram_addr    out  ADDR_W  RAM address
//   ram_wdata   out  DATA_W  RAM write data
//   ram_we      out  1       RAM write strobe, one cycle per word
//   ram_re      out  1       RAM read strobe (verify build only)
//   ram_rdata   in   DATA_W  RAM read data (valid cycle after ram_re)
//   loading_ram out  1       load in progress; CPU must stay off the RAM
//   done        out  1       load finished; level until next accepted start
//   overflow    out  1       program length exceeded capacity and was clamped
//   verify_err  out  1       read-back mismatch seen, sticky until next start
//   count       out  ADDR_W  words written so far in the current load
// ============================================================================
module cpu_ram_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              step_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_re,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              loading_ram,
  output logic              done,
  output logic              overflow,
  output logic              verify_err,
  output logic [ADDR_W-1:0] count
);

  // Length comparisons need one bit more than either the ROM word or the
  // address, since capacity can be a full 2**ADDR_W words.
  localparam int              CW        = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
  localparam logic [CW-1:0]   MAX_WORDS = CW'((2 ** ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LWAIT = 3'd2,
    S_FETCH = 3'd3,
    S_WRITE = 3'd4,
    S_VRD   = 3'd5,
    S_VCMP  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;          // index of the word being moved
  logic [CW-1:0]       n_words;      // effective (clamped) word count
  logic [DATA_W-1:0]   data_q;       // last word written, kept for read-back
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [ADDR_W-1:0]   count_q;
  logic                loading_q;
  logic                done_q;
  logic                overflow_q;

  logic [CW-1:0]       word0;
  logic [CW-1:0]       next_idx;
  logic                more;

  assign word0    = CW'(rom_data);
  assign next_idx = CW'(idx) + CW'(1);
  assign more     = (next_idx < n_words);

  // Strobes are decoded from the registered state so an asynchronous reset
  // removes them in the same cycle; no partial write can escape.
  assign rom_re    = ((state == S_LEN) || (state == S_FETCH)) && !hold;
  assign ram_we    = (state == S_WRITE);
  // During WRITE the word comes straight from the ROM output (valid this
  // cycle); otherwise the held copy is presented.
  assign ram_wdata = (state == S_WRITE) ? rom_data : data_q;

  assign rom_addr    = rom_addr_q;
  assign ram_addr    = ram_addr_q;
  assign count       = count_q;
  assign loading_ram = loading_q;
  assign done        = done_q;
  assign overflow    = overflow_q;

`ifdef CPU_LOADER_VERIFY_EN
  logic verify_err_q;
  assign ram_re     = (state == S_VRD);
  assign verify_err = verify_err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign ram_re       = 1'b0;
  assign verify_err   = 1'b0;
`endif

  always_ff @(posedge step_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      n_words    <= '0;
      data_q     <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      count_q    <= '0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CPU_LOADER_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LEN;
            idx        <= '0;
            rom_addr_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            loading_q  <= 1'b1;
`ifdef CPU_LOADER_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
          end
        end

        // rom_re is high here (unless held) with rom_addr = 0.
        S_LEN: begin
          if (!hold) begin
            state <= S_LWAIT;
          end
        end

        // Length word is on rom_data now; clamp it to the RAM capacity.
        S_LWAIT: begin
          if (word0 > MAX_WORDS) begin
            n_words    <= MAX_WORDS;
            overflow_q <= 1'b1;
          end else begin
            n_words    <= word0;
          end
          if (word0 == '0) begin
            state     <= S_DONE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state      <= S_FETCH;
            idx        <= '0;
            rom_addr_q <= ADDR_W'(1);
          end
        end

        // rom_re is high here (unless held) with rom_addr = idx + 1.
        S_FETCH: begin
          if (!hold) begin
            state      <= S_WRITE;
            ram_addr_q <= BASE + idx;
          end
        end

        S_WRITE: begin
          data_q  <= rom_data;
          count_q <= idx + ADDR_W'(1);
`ifdef CPU_LOADER_VERIFY_EN
          state   <= S_VRD;
`else
          if (more) begin
            state      <= S_FETCH;
            idx        <= idx + ADDR_W'(1);
            rom_addr_q <= idx + ADDR_W'(2);
          end else begin
            state     <= S_DONE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
          end
`endif
        end

`ifdef CPU_LOADER_VERIFY_EN
        // ram_re is high here; ram_addr still points at the word just written.
        S_VRD: begin
          state <= S_VCMP;
        end

        // A mismatch is flagged but the load carries on.
        S_VCMP: begin
          if (ram_rdata != data_q) begin
            verify_err_q <= 1'b1;
          end
          if (more) begin
            state      <= S_FETCH;
            idx        <= idx + ADDR_W'(1);
            rom_addr_q <= idx + ADDR_W'(2);
          end else begin
            state     <= S_DONE;
            loading_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ram_loader
// Description : Self-checking bench for cpu_ram_loader. Two instances:
//               dut0 (BASE_ADDR=0) for normal/hold/reset/verify loads and
//               dut1 (BASE_ADDR=250) for length clamping. Synchronous ROM
//               and RAM models live in the bench. Cycle counts are taken
//               from the clock edge that launches 'start' (start is sampled
//               one edge later).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ram_loader;

`ifdef CPU_LOADER_VERIFY_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, start1, hold0, hold1;
  logic clr_ram, corrupt0;

  logic [7:0] rom_addr0, ram_addr0, ram_wdata0, count0;
  logic [7:0] rom_data0 = 8'h00;
  logic [7:0] ram_rdata0 = 8'h00;
  logic       rom_re0, ram_we0, ram_re0, loading0, done0, ovf0, verr0;

  logic [7:0] rom_addr1, ram_addr1, ram_wdata1, count1;
  logic [7:0] rom_data1 = 8'h00;
  logic [7:0] ram_rdata1 = 8'h00;
  logic       rom_re1, ram_we1, ram_re1, loading1, done1, ovf1, verr1;

  cpu_ram_loader #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .step_clk(clk), .reset(reset), .start(start0), .hold(hold0),
    .rom_addr(rom_addr0), .rom_re(rom_re0), .rom_data(rom_data0),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0),
    .ram_re(ram_re0), .ram_rdata(ram_rdata0), .loading_ram(loading0),
    .done(done0), .overflow(ovf0), .verify_err(verr0), .count(count0)
  );

  cpu_ram_loader #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(250)) dut1 (
    .step_clk(clk), .reset(reset), .start(start1), .hold(hold1),
    .rom_addr(rom_addr1), .rom_re(rom_re1), .rom_data(rom_data1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1),
    .ram_re(ram_re1), .ram_rdata(ram_rdata1), .loading_ram(loading1),
    .done(done1), .overflow(ovf1), .verify_err(verr1), .count(count1)
  );

  // ---------------- memory models and monitors ----------------
  logic [7:0] rom0 [256];
  logic [7:0] rom1 [256];
  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  int we_cnt0 = 0, we_cnt1 = 0, re_cnt0 = 0;
  int excl0 = 0, excl1 = 0, wrap1 = 0;

  always @(posedge clk) begin
    if (clr_ram) begin
      for (int a = 0; a < 256; a++) begin
        ram0[a] <= 8'hEE;
        ram1[a] <= 8'hEE;
      end
    end else begin
      if (ram_we0) ram0[ram_addr0] <= ram_wdata0;
      if (ram_we1) ram1[ram_addr1] <= ram_wdata1;
    end
    if (rom_re0) rom_data0 <= rom0[rom_addr0];
    if (rom_re1) rom_data1 <= rom1[rom_addr1];
    if (ram_re0) ram_rdata0 <= ram0[ram_addr0] ^ ((corrupt0 && ram_addr0 == 8'd1) ? 8'hFF : 8'h00);
    if (ram_re1) ram_rdata1 <= ram1[ram_addr1];
    if (ram_we0) we_cnt0 <= we_cnt0 + 1;
    if (ram_we1) we_cnt1 <= we_cnt1 + 1;
    if (ram_re0) re_cnt0 <= re_cnt0 + 1;
    if (ram_we1 && ram_addr1 < 8'd250) wrap1 <= wrap1 + 1;
    if (int'(rom_re0) + int'(ram_we0) + int'(ram_re0) > 1) excl0 <= excl0 + 1;
    if (int'(rom_re1) + int'(ram_we1) + int'(ram_re1) > 1) excl1 <= excl1 + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch start after one edge, drop it after the next (the sampling edge).
  // Returns at sampling edge + 1, i.e. cycle 1.
  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int c0, output int cyc, output int lcnt);
    logic d, l;
    cyc  = c0;
    d    = (which == 0) ? done0 : done1;
    l    = (which == 0) ? loading0 : loading1;
    lcnt = l ? 1 : 0;
    while (!d && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      d = (which == 0) ? done0 : done1;
      l = (which == 0) ? loading0 : loading1;
      if (l) lcnt++;
    end
  endtask

  task automatic clear_ram();
    clr_ram = 1'b1;
    @(posedge clk); #1;
    clr_ram = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] w;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] len, input logic [7:0] a, b, c, d);
    vec_t v;
    v.len  = len;
    v.w[0] = a;
    v.w[1] = b;
    v.w[2] = c;
    v.w[3] = d;
    return v;
  endfunction

  function automatic logic [63:0] all_outs0();
    return {25'd0, rom_addr0, rom_re0, ram_addr0, ram_wdata0, ram_we0, ram_re0,
            loading0, done0, ovf0, verr0, count0};
  endfunction

  function automatic logic [63:0] all_outs1();
    return {25'd0, rom_addr1, rom_re1, ram_addr1, ram_wdata1, ram_we1, ram_re1,
            loading1, done1, ovf1, verr1, count1};
  endfunction

  // ---------------- stimulus ----------------
  vec_t vecs [5];
  int   cyc, lcnt, wc, n;

  initial begin
    vecs[0] = mk(8'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    vecs[1] = mk(8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk(8'd1, 8'h5A, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(8'd4, 8'h11, 8'h22, 8'h33, 8'h44);
    vecs[4] = mk(8'd2, 8'hFF, 8'h00, 8'h00, 8'h00);

    for (int a = 0; a < 256; a++) begin
      rom0[a] = 8'h77;
      rom1[a] = 8'h77;
    end

    reset    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    hold0    = 1'b0;
    hold1    = 1'b0;
    corrupt0 = 1'b0;
    clr_ram  = 1'b1;

    #12;
    check("reset_outputs_dut0", all_outs0(), 64'd0);
    check("reset_outputs_dut1", all_outs1(), 64'd0);
    @(posedge clk); #1;
    reset   = 1'b1;
    clr_ram = 1'b0;

    // ---- table-driven loads on dut0 ----
    for (int v = 0; v < 5; v++) begin
      n = int'(vecs[v].len);
      rom0[0] = vecs[v].len;
      for (int k = 0; k < 4; k++) rom0[k+1] = vecs[v].w[k];
      clear_ram();
      wc = we_cnt0;
      pulse_start(0);
      wait_done(0, 1, cyc, lcnt);
      check($sformatf("v%0d_done_cycle", v), 64'(cyc), 64'(3 + CPW * n));
      check($sformatf("v%0d_loading_cycles", v), 64'(lcnt), 64'(2 + CPW * n));
      check($sformatf("v%0d_writes", v), 64'(we_cnt0 - wc), 64'(n));
      check($sformatf("v%0d_count", v), 64'(count0), 64'(n));
      check($sformatf("v%0d_flags", v), {61'd0, ovf0, verr0, loading0}, 64'd0);
      for (int k = 0; k < n; k++)
        check($sformatf("v%0d_ram%0d", v, k), 64'(ram0[k]), 64'(vecs[v].w[k]));
      check($sformatf("v%0d_ram_beyond", v), 64'(ram0[n]), 64'hEE);
    end

    // ---- clamping on dut1: BASE 250, length 10 -> 6 words ----
    rom1[0] = 8'd10;
    for (int k = 0; k < 10; k++) rom1[k+1] = 8'h10 + 8'(k);
    clear_ram();
    pulse_start(1);
    wait_done(1, 1, cyc, lcnt);
    check("ovf_done_cycle", 64'(cyc), 64'(3 + CPW * 6));
    check("ovf_flag", 64'(ovf1), 64'd1);
    check("ovf_writes", 64'(we_cnt1), 64'd6);
    check("ovf_no_wrap", 64'(wrap1), 64'd0);
    check("ovf_count", 64'(count1), 64'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("ovf_ram%0d", 250 + k), 64'(ram1[250+k]), 64'(8'h10 + 8'(k)));
    check("ovf_ram0_untouched", 64'(ram1[0]), 64'hEE);

    // ---- hold for 5 cycles in FETCH of word 2 ----
    rom0[0] = 8'd4;
    rom0[1] = 8'h11; rom0[2] = 8'h22; rom0[3] = 8'h33; rom0[4] = 8'h44;
    clear_ram();
    wc = we_cnt0;
    pulse_start(0);
    repeat (CPW + 2) @(posedge clk);
    #1;
    hold0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("hold%0d_rom_re", k), 64'(rom_re0), 64'd0);
      check($sformatf("hold%0d_ram_we", k), 64'(ram_we0), 64'd0);
      @(posedge clk); #1;
    end
    hold0 = 1'b0;
    #1;
    check("hold_resume_rom_re", 64'(rom_re0), 64'd1);
    check("hold_resume_rom_addr", 64'(rom_addr0), 64'd2);
    wait_done(0, 8 + CPW, cyc, lcnt);
    check("hold_done_cycle", 64'(cyc), 64'(3 + CPW * 4 + 5));
    check("hold_writes", 64'(we_cnt0 - wc), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("hold_ram%0d", k), 64'(ram0[k]), 64'(rom0[k+1]));

    // ---- asynchronous reset during WRITE of word 2 of 4 ----
    clear_ram();
    pulse_start(0);
    repeat (CPW + 3) @(posedge clk);
    #1;
    check("rst_in_write", 64'(ram_we0), 64'd1);
    wc = we_cnt0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs", all_outs0(), 64'd0);
    @(posedge clk); #1;
    check("rst_no_partial_write", 64'(we_cnt0 - wc), 64'd0);
    check("rst_ram1_unwritten", 64'(ram0[1]), 64'hEE);
    reset = 1'b1;
    clear_ram();
    wc = we_cnt0;
    pulse_start(0);
    wait_done(0, 1, cyc, lcnt);
    check("reload_done_cycle", 64'(cyc), 64'(3 + CPW * 4));
    check("reload_writes", 64'(we_cnt0 - wc), 64'd4);
    check("reload_count", 64'(count0), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("reload_ram%0d", k), 64'(ram0[k]), 64'(rom0[k+1]));

`ifdef CPU_LOADER_VERIFY_EN
    // ---- read-back corruption of word 1 ----
    rom0[0] = 8'd3;
    rom0[1] = 8'hA1; rom0[2] = 8'hB2; rom0[3] = 8'hC3;
    clear_ram();
    wc = we_cnt0;
    corrupt0 = 1'b1;
    pulse_start(0);
    repeat (9) @(posedge clk);
    #1;
    check("verr_before_vcmp1", 64'(verr0), 64'd0);
    @(posedge clk); #1;
    check("verr_after_vcmp1", 64'(verr0), 64'd1);
    wait_done(0, 11, cyc, lcnt);
    check("verr_done_cycle", 64'(cyc), 64'(3 + CPW * 3));
    check("verr_sticky", 64'(verr0), 64'd1);
    check("verr_writes", 64'(we_cnt0 - wc), 64'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("verr_ram%0d", k), 64'(ram0[k]), 64'(rom0[k+1]));
    corrupt0 = 1'b0;
    pulse_start(0);
    check("verr_cleared_by_start", {62'd0, verr0, done0}, 64'd0);
    wait_done(0, 1, cyc, lcnt);
    check("verr_clean_reload", 64'(verr0), 64'd0);
    check("verify_reads", 64'(re_cnt0 > 0), 64'd1);
`else
    check("no_ram_re", 64'(re_cnt0), 64'd0);
    check("no_verify_err", 64'(verr0), 64'd0);
`endif

    check("strobe_exclusive_dut0", 64'(excl0), 64'd0);
    check("strobe_exclusive_dut1", 64'(excl1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
